lsu: RTL

Load/store unit sitting directly downstream of the execute/control stage of the core, between it and the system bus (sb). It accepts one memory request at a time from execute and holds the pipeline while the access is in flight. It drives a request/grant/response handshake on the bus, byte-aligns store data with write strobes, and extracts and sign/zero-extends load data. Load results are returned to the register file as a one-cycle write.

---
 rtl/lsu.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between execute and the system bus (sb); optional LSU_MISALIGN_TRAP_EN.
// Latency: accept -> REQ -> WAIT -> DONE, 3 cycles minimum plus one per grant or response wait cycle.
// Backpressure: hold_o stalls execute from accept until DONE; sb_req_o stays up until sb_gnt_i.
module lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [2:0]        byte_sel_i,
    input  logic [4:0]        rd_waddr_i,
    output logic              hold_o,
    output logic              rd_we_o,
    output logic [4:0]        rd_waddr_o,
    output logic [DATA_W-1:0] rd_wdata_o,
    output logic              sb_req_o,
    output logic              sb_we_o,
    output logic [ADDR_W-1:0] sb_addr_o,
    output logic [DATA_W-1:0] sb_wdata_o,
    output logic [3:0]        sb_wstrb_o,
    input  logic              sb_gnt_i,
    input  logic              sb_rvalid_i,
    input  logic [DATA_W-1:0] sb_rdata_i
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              misalign_o
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [2:0] SEL_B  = 3'b000;
    localparam logic [2:0] SEL_H  = 3'b001;
    localparam logic [2:0] SEL_BU = 3'b100;
    localparam logic [2:0] SEL_HU = 3'b101;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        sel_q, sel_d;
    logic [4:0]        rd_waddr_q, rd_waddr_d;
    logic              sb_req_q, sb_req_d;
    logic [DATA_W-1:0] sb_wdata_q, sb_wdata_d;
    logic [3:0]        sb_wstrb_q, sb_wstrb_d;
    logic              rd_we_q, rd_we_d;
    logic [DATA_W-1:0] rd_wdata_q, rd_wdata_d;

    logic              is_byte_in;
    logic              is_half_in;
    logic              misal_acc;

    assign is_byte_in = (byte_sel_i == SEL_B) || (byte_sel_i == SEL_BU);
    assign is_half_in = (byte_sel_i == SEL_H) || (byte_sel_i == SEL_HU);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign misal_acc  = is_half_in ? addr_i[0]
                                   : (!is_byte_in && (addr_i[1:0] != 2'b00));
    assign misalign_o = misalign_q;
`else
    assign misal_acc  = 1'b0;
`endif

    function automatic logic [31:0] store_data(input logic [2:0] sel, input logic [31:0] w);
        case (sel)
            SEL_B, SEL_BU: store_data = {4{w[7:0]}};
            SEL_H, SEL_HU: store_data = {2{w[15:0]}};
            default:       store_data = w;
        endcase
    endfunction

    // Without the trap, misaligned halfwords/words silently drop the low address bits.
    function automatic logic [3:0] store_strb(input logic [2:0] sel, input logic [1:0] a);
        case (sel)
            SEL_B, SEL_BU: store_strb = 4'b0001 << a;
            SEL_H, SEL_HU: store_strb = a[1] ? 4'b1100 : 4'b0011;
            default:       store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] sel);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (sel)
            SEL_B:   load_ext = {{24{b[7]}}, b};
            SEL_BU:  load_ext = {24'd0, b};
            SEL_H:   load_ext = {{16{h[15]}}, h};
            SEL_HU:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        sel_d      = sel_q;
        rd_waddr_d = rd_waddr_q;
        sb_req_d   = sb_req_q;
        sb_wdata_d = sb_wdata_q;
        sb_wstrb_d = sb_wstrb_q;
        rd_we_d    = rd_we_q;
        rd_wdata_d = rd_wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d       = we_i;
                    addr_d     = addr_i;
                    sel_d      = byte_sel_i;
                    rd_waddr_d = rd_waddr_i;
                    sb_wdata_d = store_data(byte_sel_i, wdata_i);
                    sb_wstrb_d = we_i ? store_strb(byte_sel_i, addr_i[1:0]) : 4'b0000;
                    if (misal_acc) begin
                        state_d = DONE;
`ifdef LSU_MISALIGN_TRAP_EN
                        misalign_d = 1'b1;
`endif
                    end else begin
                        state_d  = REQ;
                        sb_req_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (sb_gnt_i) begin
                    sb_req_d = 1'b0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (sb_rvalid_i) begin
                    rd_wdata_d = load_ext(sb_rdata_i, addr_q[1:0], sel_q);
                    rd_we_d    = !we_q && (rd_waddr_q != 5'd0);
                    state_d    = DONE;
                end
            end
            DONE: begin
                rd_we_d = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                misalign_d = 1'b0;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            sel_q      <= 3'd0;
            rd_waddr_q <= 5'd0;
            sb_req_q   <= 1'b0;
            sb_wdata_q <= '0;
            sb_wstrb_q <= 4'd0;
            rd_we_q    <= 1'b0;
            rd_wdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            rd_waddr_q <= rd_waddr_d;
            sb_req_q   <= sb_req_d;
            sb_wdata_q <= sb_wdata_d;
            sb_wstrb_q <= sb_wstrb_d;
            rd_we_q    <= rd_we_d;
            rd_wdata_q <= rd_wdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // hold_o is the only combinational output: execute must stall in the accept cycle itself.
    assign hold_o     = ((state_q == IDLE) && req_i) || (state_q == REQ) || (state_q == WAIT);
    assign rd_we_o    = rd_we_q;
    assign rd_waddr_o = rd_waddr_q;
    assign rd_wdata_o = rd_wdata_q;
    assign sb_req_o   = sb_req_q;
    assign sb_we_o    = we_q;
    assign sb_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
    assign sb_wdata_o = sb_wdata_q;
    assign sb_wstrb_o = sb_wstrb_q;

endmodule
